// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register bank's single write port among NUM_REQ requesters.
// Emits one registered write per cycle and a one-hot per-register enable vector.
module regfile_write_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ADDR_WIDTH  = 5,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ZERO_REG_RO = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  input  logic                            hold,
  output logic [NUM_REQ-1:0]              grant,
  output logic                            wr_valid,
  output logic [ADDR_WIDTH-1:0]           wr_addr,
  output logic [DATA_WIDTH-1:0]           wr_data,
  output logic [(1<<ADDR_WIDTH)-1:0]      reg_enable,
  output logic                            busy
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

  logic [NUM_REQ-1:0]    elig;
  logic [PTR_W-1:0]      ptr;
  logic [PTR_W-1:0]      ptr_nxt;
  logic [PTR_W-1:0]      win;
  logic                  found;
  logic                  wr_hit;
  logic [NUM_REQ-1:0]    grant_nxt;
  logic                  wr_valid_nxt;
  logic [ADDR_WIDTH-1:0] wr_addr_nxt;
  logic [DATA_WIDTH-1:0] wr_data_nxt;
  logic [DEPTH-1:0]      reg_enable_nxt;

  // Unpack the flat request buses into per-requester views.
  always_comb begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      addr_arr[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // The requester granted this cycle is masked so a held request is not granted twice.
  assign elig = req & ~grant;
  assign busy = |elig;

  // Round-robin search starting at ptr, wrapping modulo NUM_REQ.
  always_comb begin
    int s;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      s = int'(ptr) + k;
      if (s >= int'(NUM_REQ)) s = s - int'(NUM_REQ);
      if (!found && elig[PTR_W'(s)]) begin
        found = 1'b1;
        win   = PTR_W'(s);
      end
    end
  end

  // Next-state for the write port; address/data hold when nothing is granted.
  always_comb begin
    grant_nxt      = '0;
    wr_valid_nxt   = 1'b0;
    wr_addr_nxt    = wr_addr;
    wr_data_nxt    = wr_data;
    ptr_nxt        = ptr;
    reg_enable_nxt = '0;
    wr_hit         = found && !hold;
    if (wr_hit) begin
      grant_nxt[win] = 1'b1;
      wr_addr_nxt    = addr_arr[win];
      wr_data_nxt    = data_arr[win];
      wr_valid_nxt   = !((ZERO_REG_RO != 0) && (addr_arr[win] == '0));
      if (int'(win) + 1 >= int'(NUM_REQ)) ptr_nxt = '0;
      else                                ptr_nxt = win + PTR_W'(1);
    end
    if (wr_valid_nxt) reg_enable_nxt[wr_addr_nxt] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant      <= '0;
      wr_valid   <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      reg_enable <= '0;
      ptr        <= '0;
    end else begin
      grant      <= grant_nxt;
      wr_valid   <= wr_valid_nxt;
      wr_addr    <= wr_addr_nxt;
      wr_data    <= wr_data_nxt;
      reg_enable <= reg_enable_nxt;
      ptr        <= ptr_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios with literal expectations,
// then random traffic, all cross-checked every cycle against a behavioural model.
module tb_regfile_write_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  logic              clk;
  logic              rst;
  logic [NR-1:0]     req;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_data;
  logic              hold;
  logic [NR-1:0]     grant;
  logic              wr_valid;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic [(1<<AW)-1:0] reg_enable;
  logic              busy;

  logic [AW-1:0] a_arr [NR];
  logic [DW-1:0] d_arr [NR];

  int n_checks = 0;
  int n_fail   = 0;

  regfile_write_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ZERO_REG_RO(1)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
    .hold(hold), .grant(grant), .wr_valid(wr_valid), .wr_addr(wr_addr),
    .wr_data(wr_data), .reg_enable(reg_enable), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < int'(NR); i++) begin
      req_addr[i*AW +: AW] = a_arr[i];
      req_data[i*DW +: DW] = d_arr[i];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: pending = req minus whoever holds the grant; rotate priority after each win.
  int            m_ptr   = 0;
  logic [NR-1:0] m_grant = '0;
  logic          m_valid = 1'b0;
  logic [AW-1:0] m_addr  = '0;
  logic [DW-1:0] m_data  = '0;

  function automatic int pick(input logic [NR-1:0] e, input int p);
    for (int k = 0; k < int'(NR); k++)
      if (e[(p + k) % int'(NR)]) return (p + k) % int'(NR);
    return -1;
  endfunction

  always @(posedge clk or negedge rst) begin
    logic [NR-1:0] pending;
    int w;
    if (!rst) begin
      m_ptr = 0; m_grant = '0; m_valid = 1'b0; m_addr = '0; m_data = '0;
    end else begin
      pending = req & ~m_grant;
      w = pick(pending, m_ptr);
      if (!hold && w >= 0) begin
        m_grant = '0;
        m_grant[w] = 1'b1;
        m_addr  = a_arr[w];
        m_data  = d_arr[w];
        m_valid = (a_arr[w] != '0);
        m_ptr   = (w + 1) % int'(NR);
      end else begin
        m_grant = '0;
        m_valid = 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    logic [63:0] exp_en;
    exp_en = m_valid ? (64'd1 << m_addr) : 64'd0;
    check("grant",      64'(grant),      64'(m_grant));
    check("wr_valid",   64'(wr_valid),   64'(m_valid));
    check("wr_addr",    64'(wr_addr),    64'(m_addr));
    check("wr_data",    64'(wr_data),    64'(m_data));
    check("reg_enable", 64'(reg_enable), exp_en);
    check("busy",       64'(busy),       64'(|(req & ~m_grant)));
    check("grant_onehot", 64'($countones(grant) <= 1), 64'd1);
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic peek();
    #4;
  endtask

  task automatic put(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i]   = 1'b1;
    a_arr[i] = a;
    d_arr[i] = d;
  endtask

  task automatic do_reset();
    rst  = 1'b0;
    req  = '0;
    hold = 1'b0;
    cyc();
    rst  = 1'b1;
  endtask

  initial begin
    logic [NR-1:0] rr_seq [8];
    rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    rst = 1'b0; req = '0; hold = 1'b0;
    for (int i = 0; i < int'(NR); i++) begin a_arr[i] = '0; d_arr[i] = '0; end

    // Reset state
    repeat (2) cyc();
    peek();
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_valid", 64'(wr_valid), 64'd0);
    check("rst_en", 64'(reg_enable), 64'd0);

    // Single requester
    cyc();
    rst = 1'b1;
    put(2, 5'd9, 32'hDEAD_BEEF);
    cyc();
    req = '0;
    peek();
    check("single_grant", 64'(grant), 64'h4);
    check("single_valid", 64'(wr_valid), 64'd1);
    check("single_addr", 64'(wr_addr), 64'd9);
    check("single_data", 64'(wr_data), 64'hDEAD_BEEF);
    check("single_en", 64'(reg_enable), 64'h200);
    cyc();
    peek();
    check("single_after_grant", 64'(grant), 64'd0);
    check("single_after_en", 64'(reg_enable), 64'd0);
    // Pointer now at 3: all-request picks requester 3 first
    for (int i = 0; i < int'(NR); i++) put(i, AW'(i + 1), DW'(i));
    cyc();
    req = '0;
    peek();
    check("ptr3_grant", 64'(grant), 64'h8);
    check("ptr3_addr", 64'(wr_addr), 64'd4);

    // Round robin from reset
    do_reset();
    for (int i = 0; i < int'(NR); i++) put(i, AW'(10 + i), DW'(32'h100 + i));
    for (int k = 0; k < 8; k++) begin
      cyc();
      peek();
      check("rr_grant", 64'(grant), 64'(rr_seq[k]));
    end
    req = '0;

    // Zero register write is granted but suppressed
    do_reset();
    put(0, 5'd0, 32'h1234);
    cyc();
    req = '0;
    peek();
    check("zero_grant", 64'(grant), 64'h1);
    check("zero_valid", 64'(wr_valid), 64'd0);
    check("zero_en", 64'(reg_enable), 64'd0);
    check("zero_data", 64'(wr_data), 64'h1234);

    // Hold stalls new grants
    do_reset();
    put(0, 5'd3, 32'hA0);
    put(1, 5'd5, 32'hA1);
    hold = 1'b1;
    repeat (3) begin
      cyc();
      peek();
      check("hold_grant", 64'(grant), 64'd0);
      check("hold_valid", 64'(wr_valid), 64'd0);
      check("hold_busy", 64'(busy), 64'd1);
    end
    hold = 1'b0;
    cyc();
    peek();
    check("unhold_grant0", 64'(grant), 64'h1);
    req[0] = 1'b0;
    cyc();
    peek();
    check("unhold_grant1", 64'(grant), 64'h2);

    // Asynchronous reset between edges
    rst = 1'b0;
    #1;
    check("async_grant", 64'(grant), 64'd0);
    check("async_valid", 64'(wr_valid), 64'd0);
    check("async_en", 64'(reg_enable), 64'd0);
    req = 4'b0010;
    cyc();
    rst = 1'b1;
    cyc();
    peek();
    check("post_rst_grant", 64'(grant), 64'h2);
    check("post_rst_addr", 64'(wr_addr), 64'd5);
    for (int i = 0; i < int'(NR); i++) put(i, AW'(20 + i), DW'(i));
    cyc();
    req = '0;
    peek();
    check("post_rst_ptr", 64'(grant), 64'h4);

    // Continuous single requester: grant every other cycle
    do_reset();
    put(3, 5'd7, 32'h77);
    for (int k = 0; k < 6; k++) begin
      cyc();
      peek();
      check("cont_grant", 64'(grant), (k % 2 == 0) ? 64'h8 : 64'h0);
      check("cont_valid", 64'(wr_valid), (k % 2 == 0) ? 64'd1 : 64'd0);
    end
    req = '0;

    // Random traffic
    do_reset();
    for (int n = 0; n < 400; n++) begin
      cyc();
      if (n == 200) begin
        rst = 1'b0;
        req = '0;
        continue;
      end
      rst  = 1'b1;
      hold = ($urandom % 6) == 0;
      for (int i = 0; i < int'(NR); i++) begin
        if (req[i] && grant[i]) begin
          if ($urandom_range(0, 1) == 1)
            put(i, (($urandom % 8) == 0) ? AW'(0) : AW'($urandom), DW'($urandom));
          else
            req[i] = 1'b0;
        end else if (req[i]) begin
          if (($urandom % 16) == 0) req[i] = 1'b0;
        end else if (($urandom % 3) == 0) begin
          put(i, (($urandom % 8) == 0) ? AW'(0) : AW'($urandom), DW'($urandom));
        end
      end
    end
    req = '0;
    hold = 1'b0;
    repeat (3) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single write port of the D-flip-flop register bank among NUM_REQ requesters (e.g. writeback, load return, coprocessor move).
- Uses round-robin arbitration.
- Drives one registered write per cycle as wr_addr/wr_data plus a one-hot per-register enable vector that feeds the flip-flop enable inputs directly.
- Register 0 is hardwired zero when ZERO_REG_RO=1.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_WIDTH, 5, register address width; bank depth = 2**ADDR_WIDTH
- DATA_WIDTH, 32, register data width
- ZERO_REG_RO, 1, 1 = writes to address 0 are granted but suppressed

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous reset, active-low (rst=0 resets immediately, independent of clk)
- req  in  NUM_REQ  per-requester write request; held high until granted
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_data  in  NUM_REQ*DATA_WIDTH  packed data; same packing
- hold  in  1  pipeline stall; blocks new grants
- grant  out  NUM_REQ  one-hot, registered, one-cycle pulse per accepted write
- wr_valid  out  1  registered write strobe
- wr_addr  out  ADDR_WIDTH  registered write address
- wr_data  out  DATA_WIDTH  registered write data
- reg_enable  out  2**ADDR_WIDTH  one-hot decode of wr_addr, gated by wr_valid
- busy  out  1  combinational: any req bit high and not currently granted

Behaviour:
- Reset (rst=0, asynchronous): grant=0, wr_valid=0, wr_addr=0, wr_data=0, reg_enable=0, priority pointer ptr=0. A grant or write in flight is dropped, never completed. The first edge after rst rises arbitrates normally.
- Eligible set at each posedge: elig = req & ~grant.
  - The currently granted requester is excluded, so a held request is never double-granted.
  - If that requester keeps req high in the next cycle, it is a new request.
- Arbitration at posedge, when hold=0 and elig≠0:
  - Winner w = first set bit of elig, scanning ptr, ptr+1, …, wrapping modulo NUM_REQ.
  - Next cycle: grant=(1<<w), wr_addr=req_addr[w], wr_data=req_data[w], wr_valid=1.
  - ptr ← (w+1) mod NUM_REQ.
- Latency: req sampled at edge k → grant and write visible in cycle k+1 → register bank captures on edge k+2. A solitary request sees grant 1 cycle after it is sampled.
- When hold=1 or elig=0 at a posedge:
  - grant=0 and wr_valid=0 next cycle.
  - wr_addr and wr_data hold their previous values.
  - ptr unchanged.
  - hold does not cancel a grant already issued in the current cycle.
- Zero register, with ZERO_REG_RO=1 and winning address 0:
  - grant pulses normally and ptr advances.
  - wr_valid=0, so reg_enable=0.
  - wr_addr=0 and wr_data still load.
- reg_enable[j] = wr_valid && (wr_addr==j). At most one bit set; all zero when wr_valid=0.
- Throughput:
  - One write per cycle when two or more requesters alternate.
  - A single requester holding req continuously gets a grant every other cycle, because of the exclusion mask.
- Fairness: with all NUM_REQ requesters continuously high, each is granted exactly once in any NUM_REQ consecutive grants.
- Requirements on requesters (bench checks these, the block assumes them):
  - req_addr and req_data stay stable while req is high and ungranted.
  - req may drop without a grant; the request is then withdrawn.
- No combinational path from inputs to grant, wr_*, or reg_enable. busy is the only combinational output.

Test Plan:
- Single requester: rst released, req=4'b0100, req_addr[2]=5'd9, req_data[2]=32'hDEAD_BEEF, held 1 cycle then dropped → next cycle grant=4'b0100, wr_valid=1, wr_addr=9, reg_enable=1<<9; following cycle all zero; ptr=3.
- Round robin: from reset, req=4'b1111 held 8 cycles with distinct addresses → grants in order 0,1,2,3,0,1,2,3 (but requester 0's repeat is delayed one cycle by the exclusion mask only if it was last granted); no cycle with two grant bits set.
- Zero register: req=4'b0001 with req_addr[0]=0, data 32'h1234 → grant=4'b0001 pulses; wr_valid=0; reg_enable=0.
- Hold: req=4'b0011, hold=1 for 3 cycles → grant=0 and wr_valid=0 throughout, ptr unchanged, busy=1; hold drops → grant=4'b0001, then 4'b0010.
- Reset mid-operation: rst pulled low between edges while grant=4'b0010 → grant, wr_valid, reg_enable go 0 before the next edge; after release with req=4'b0010 → requester 1 granted, ptr restarted from 0.
- Continuous single requester: req=4'b1000 held 6 cycles → grant=4'b1000 on alternating cycles (3 grants total), wr_valid matching.
